// File: rtl/aes_pkg.sv
// Shared AES constants, GF(2^8) helper and types for the cipher core and the
// round-key expander. Bytes are little-endian: FIPS byte n sits at bits [8n+:8].
package aes_pkg;

    typedef logic [15:0][7:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        KEYWAIT = 2'd1,
        ROUND   = 2'd2,
        DONE    = 2'd3
    } cipher_st_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Multiply by {02} in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns
// (bypassed on the final round) and AddRoundKey.
module aes_round
    import aes_pkg::*;
(
    input  aes_state_t   state,
    input  logic [127:0] rk,
    input  logic         final_rnd,
    output aes_state_t   next_state
);

    aes_state_t sub;
    aes_state_t shf;
    aes_state_t mix;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sub[i] = SBOX[state[i]];
        end

        // Byte 4c+r is row r of column c; row r takes its byte from column c+r.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shf[4*c + r] = sub[4*((c + r) % 4) + r];
            end
        end

        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                mix[4*c + r] = xtime(shf[4*c + r])
                             ^ xtime(shf[4*c + (r + 1) % 4]) ^ shf[4*c + (r + 1) % 4]
                             ^ shf[4*c + (r + 2) % 4]
                             ^ shf[4*c + (r + 3) % 4];
            end
        end

        next_state = (final_rnd ? shf : mix) ^ rk;
    end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryptor, one round per clock, fed by an external round-key
// expander. Optional AES_RK_ORDER_CHECK_EN adds a sticky rk_err for skipped keys.
module aes_cipher_iter
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         key_load,
    input  logic [127:0] rk,
    input  logic [4:0]   rk_idx
`ifdef AES_RK_ORDER_CHECK_EN
    ,
    output logic         rk_err
`endif
);

    localparam logic [4:0] NR_IDX = 5'(Nr);

    cipher_st_e state_q;
    cipher_st_e state_d;
    aes_state_t st_q;
    aes_state_t round_out;
    logic [4:0] r_q;
    logic       accept;
    logic       key_hit;
    logic       final_rnd;

    assign accept    = in_valid && in_ready;
    assign key_hit   = (rk_idx == r_q);
    assign final_rnd = (r_q == NR_IDX);

`ifdef AES_RK_ORDER_CHECK_EN
    logic order_err;
    // A key index beyond the current round but still in range means the expander skipped one.
    assign order_err = ((state_q == KEYWAIT) || (state_q == ROUND))
                    && (rk_idx <= NR_IDX) && (rk_idx > r_q);
`endif

    aes_round u_round (
        .state      (st_q),
        .rk         (rk),
        .final_rnd  (final_rnd),
        .next_state (round_out)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d defaults to the current state so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = KEYWAIT;
            KEYWAIT: if (key_hit) state_d = ROUND;
            ROUND:   if (key_hit && final_rnd) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef AES_RK_ORDER_CHECK_EN
        if (order_err) state_d = IDLE;
`endif
    end

    always_comb begin
        key_load  = (state_q == KEYWAIT) || (state_q == ROUND);
        out_valid = (state_q == DONE);
    end

    // in_ready is registered from the next state so it reads 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b0;
            st_q     <= '0;
            r_q      <= '0;
            out_data <= '0;
        end else begin
            in_ready <= (state_d == IDLE);
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        st_q <= in_data;
                        r_q  <= '0;
                    end
                end
                KEYWAIT: begin
                    if (key_hit) begin
                        st_q <= st_q ^ rk;
                        r_q  <= 5'd1;
                    end
                end
                ROUND: begin
                    if (key_hit) begin
                        st_q <= round_out;
                        if (final_rnd) begin
                            out_data <= round_out;
                        end else begin
                            r_q <= r_q + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef AES_RK_ORDER_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_err <= 1'b0;
        end else if (order_err) begin
            rk_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Bench for aes_cipher_iter: Nk=4 and Nk=8 instances fed by behavioural key
// expanders, checked against a byte-level AES model built from GF(2^8) arithmetic.
module tb_aes_cipher_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_data;

    logic         in_ready4, out_valid4, key_load4;
    logic [127:0] out_data4, rk4;
    logic [4:0]   rk_idx4;
    logic         in_ready8, out_valid8, key_load8;
    logic [127:0] out_data8, rk8;
    logic [4:0]   rk_idx8;
`ifdef AES_RK_ORDER_CHECK_EN
    logic         rk_err4, rk_err8;
`endif

    always #5 clk = ~clk;

    aes_cipher_iter #(.Nk(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .key_load(key_load4), .rk(rk4), .rk_idx(rk_idx4)
`ifdef AES_RK_ORDER_CHECK_EN
        , .rk_err(rk_err4)
`endif
    );

    aes_cipher_iter #(.Nk(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data),
        .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
        .key_load(key_load8), .rk(rk8), .rk_idx(rk_idx8)
`ifdef AES_RK_ORDER_CHECK_EN
        , .rk_err(rk_err8)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]   sb [256];
    logic [127:0] rks4 [15];
    logic [127:0] rks8 [15];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = (x[7]) ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv, b, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            b = inv;
            s = inv;
            for (int k = 0; k < 4; k++) begin
                b = {b[6:0], b[7]};
                s = s ^ b;
            end
            sb[x] = s ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [255:0] key, input int nk);
        logic [7:0]   w [60][4];
        logic [7:0]   t [4];
        logic [7:0]   t0;
        logic [7:0]   rc;
        logic [127:0] rkv;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++)
            for (int j = 0; j < 4; j++) w[i][j] = key[8*(4*i + j) +: 8];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
            if (i % nk == 0) begin
                t0   = t[0];
                t[0] = sb[t[1]] ^ rc;
                t[1] = sb[t[2]];
                t[2] = sb[t[3]];
                t[3] = sb[t0];
                rc   = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                for (int j = 0; j < 4; j++) t[j] = sb[t[j]];
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-nk][j] ^ t[j];
        end
        for (int r = 0; r <= nr; r++) begin
            rkv = '0;
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++) rkv[8*(4*c + j) +: 8] = w[4*r + c][j];
            if (nk == 4) rks4[r] = rkv;
            else         rks8[r] = rkv;
        end
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nk);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] k;
        logic [127:0] res;
        int nr;
        nr = nk + 6;
        k = (nk == 4) ? rks4[0] : rks8[0];
        for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ k[8*i +: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4*c + r] = t[4*((c + r) % 4) + r];
            if (rnd < nr) begin
                for (int i = 0; i < 16; i++) t[i] = s[i];
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        s[4*c + r] = gmul(8'h02, t[4*c + r]) ^ gmul(8'h03, t[4*c + (r+1) % 4])
                                   ^ t[4*c + (r+2) % 4] ^ t[4*c + (r+3) % 4];
            end
            k = (nk == 4) ? rks4[rnd] : rks8[rnd];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[8*i +: 8];
        end
        for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
        return res;
    endfunction

    // ---------------- behavioural key expanders ----------------
    // One idle cycle after key_load rises, then one key per cycle; dut4's can stall or skip.
    int stall_idx   = 31;
    int stall_extra = 0;
    int skip_idx    = 31;
    int cnt4, held4, cnt8;

    function automatic logic [4:0] idx_of(input int n);
        return (n > 15) ? 5'd31 : 5'(n);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !key_load4) begin
            cnt4    <= 0;
            held4   <= 0;
            rk_idx4 <= 5'd31;
        end else if (rk_idx4 == 5'(stall_idx) && held4 < stall_extra) begin
            held4 <= held4 + 1;
        end else begin
            held4 <= 0;
            if (cnt4 == 0) begin
                rk_idx4 <= 5'd31;
                cnt4    <= 1;
            end else if (cnt4 - 1 == skip_idx) begin
                rk_idx4 <= idx_of(cnt4);
                cnt4    <= cnt4 + 2;
            end else begin
                rk_idx4 <= idx_of(cnt4 - 1);
                cnt4    <= cnt4 + 1;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !key_load8) begin
            cnt8    <= 0;
            rk_idx8 <= 5'd31;
        end else begin
            rk_idx8 <= (cnt8 == 0) ? 5'd31 : idx_of(cnt8 - 1);
            cnt8    <= cnt8 + 1;
        end
    end

    assign rk4 = (rk_idx4 < 5'd15) ? rks4[rk_idx4[3:0]] : '0;
    assign rk8 = (rk_idx8 < 5'd15) ? rks8[rk_idx8[3:0]] : '0;

    // ---------------- stimulus helpers ----------------
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!(in_ready4 && in_ready8) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, " idle ready"}, {in_ready4, in_ready8}, 2'b11);
    endtask

    task automatic accept_block(input logic [127:0] pt);
        in_data  = pt;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_block(input string name, input logic [127:0] pt, input logic [255:0] key,
                             input logic [127:0] exp4, input logic [127:0] exp8,
                             input int exp_lat4, input int bp, input bit noise, input int abort_at);
        logic [127:0] d4, d8;
        int  lat, lat4, lat8, held;
        bit  got4, got8, done4, done8;
        expand_key(key, 4);
        expand_key(key, 8);
        out_ready = (bp == 0);
        wait_ready(name);
        accept_block(pt);
        lat = 0; lat4 = 0; lat8 = 0; held = 0;
        got4 = 0; got8 = 0; done4 = 0; done8 = 0;
        d4 = '0; d8 = '0;
        while (!(done4 && done8) && lat < 120) begin
            @(posedge clk);
            lat++;
            if (noise) begin
                #1;
                in_valid = (lat < 4);
                in_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            if (noise && lat == 2) check({name, " busy in_ready"}, in_ready4, 1'b0);
            if (abort_at != 0 && lat == abort_at) begin
                check({name, " busy before reset"}, key_load4, 1'b1);
                #2 rst_n = 1'b0;
                #1;
                check({name, " rst in_ready"},  {in_ready4, in_ready8}, 2'b00);
                check({name, " rst out_valid"}, {out_valid4, out_valid8}, 2'b00);
                check({name, " rst key_load"},  {key_load4, key_load8}, 2'b00);
                check({name, " rst out_data4"}, out_data4, '0);
                check({name, " rst out_data8"}, out_data8, '0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (out_valid4 && !got4) begin
                got4 = 1; lat4 = lat; d4 = out_data4;
                check({name, " done4 key_load"}, key_load4, 1'b0);
                check({name, " done4 in_ready"}, in_ready4, 1'b0);
            end
            if (out_valid8 && !got8) begin
                got8 = 1; lat8 = lat; d8 = out_data8;
            end
            if (got4 && out_valid4 && !out_ready) begin
                check({name, " held data"}, out_data4, d4);
                check({name, " held in_ready/key_load"}, {in_ready4, key_load4}, 2'b00);
                held++;
                if (held == bp) out_ready = 1'b1;
            end
            if (got4 && !out_valid4 && !done4) begin
                done4 = 1;
                check({name, " release cycles"}, lat - lat4, (bp == 0) ? 1 : bp);
            end
            if (got8 && !out_valid8) done8 = 1;
        end
        out_ready = 1'b1;
        check({name, " completed"}, {done4, done8}, 2'b11);
        check({name, " data Nk4"}, d4, exp4);
        check({name, " data Nk8"}, d8, exp8);
        check({name, " latency Nk4"}, lat4, exp_lat4);
        check({name, " latency Nk8"}, lat8, 17);
    endtask

    // ---------------- test sequence ----------------
    typedef struct {
        logic [127:0] pt;
        logic [255:0] key;
        logic [127:0] exp4;
        logic [127:0] exp8;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        build_sbox();

        vecs[0].pt   = 128'hffeeddccbbaa99887766554433221100;
        vecs[0].key  = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
        vecs[0].exp4 = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
        vecs[0].exp8 = 128'h8960494b9049fceabf456751cab7a28e;
        for (int i = 1; i < 5; i++) begin
            vecs[i].pt  = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            expand_key(vecs[i].key, 4);
            vecs[i].exp4 = encrypt(vecs[i].pt, 4);
            expand_key(vecs[i].key, 8);
            vecs[i].exp8 = encrypt(vecs[i].pt, 8);
        end

        repeat (3) @(negedge clk);
        check("reset in_ready",  {in_ready4, in_ready8}, 2'b00);
        check("reset out_valid", {out_valid4, out_valid8}, 2'b00);
        check("reset key_load",  {key_load4, key_load8}, 2'b00);
        check("reset out_data4", out_data4, '0);
        check("reset out_data8", out_data8, '0);
`ifdef AES_RK_ORDER_CHECK_EN
        check("reset rk_err", {rk_err4, rk_err8}, 2'b00);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++)
            run_block($sformatf("vec%0d", i), vecs[i].pt, vecs[i].key, vecs[i].exp4, vecs[i].exp8,
                      13, 0, (i == 2), 0);

        run_block("backpressure", vecs[0].pt, vecs[0].key, vecs[0].exp4, vecs[0].exp8, 13, 5, 0, 0);

        stall_idx   = 3;
        stall_extra = 4;
        run_block("stall", vecs[1].pt, vecs[1].key, vecs[1].exp4, vecs[1].exp8, 17, 0, 0, 0);
        stall_idx   = 31;
        stall_extra = 0;

        run_block("abort", vecs[3].pt, vecs[3].key, vecs[3].exp4, vecs[3].exp8, 13, 0, 0, 8);
        run_block("after reset", vecs[3].pt, vecs[3].key, vecs[3].exp4, vecs[3].exp8, 13, 0, 0, 0);

        // Expander for dut4 jumps from key 2 to key 4.
        skip_idx = 3;
        expand_key(vecs[4].key, 4);
        expand_key(vecs[4].key, 8);
        wait_ready("skip");
        accept_block(vecs[4].pt);
        seen = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (out_valid4) seen = 1;
        end
        check("skip no out_valid", seen, 1'b0);
`ifdef AES_RK_ORDER_CHECK_EN
        check("skip rk_err4", rk_err4, 1'b1);
        check("skip rk_err8", rk_err8, 1'b0);
        check("skip back to idle", {in_ready4, key_load4}, 2'b10);
`else
        check("skip still stalled", {in_ready4, key_load4}, 2'b01);
`endif
        skip_idx = 31;
        rst_n = 1'b0;
        @(negedge clk);
`ifdef AES_RK_ORDER_CHECK_EN
        check("rk_err cleared", rk_err4, 1'b0);
`endif
        check("skip reset key_load", key_load4, 1'b0);
        rst_n = 1'b1;

        run_block("recover", vecs[4].pt, vecs[4].key, vecs[4].exp4, vecs[4].exp8, 13, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_cipher_iter.md
Name: aes_cipher_iter

Overview:
- Iterative AES encryption core, one round per clock. Sits directly downstream of the round-key expander.
- Drives the expander's load input (key_load) and consumes its stream of round keys (rk, rk_idx).
- Accepts one 128-bit plaintext block through a valid/ready handshake and returns the ciphertext through a valid/ready handshake.
- Byte packing is little-endian: FIPS byte n sits at data[8n+:8]. The same convention applies to keys.

Parameters:
- Nk, 4, key length in 32-bit words (4/6/8).
- Nr, Nk+6, number of rounds.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- in_valid  in  1  plaintext valid.
- in_ready  out  1  core can accept plaintext.
- in_data  in  128  plaintext.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  sink accepts ciphertext.
- out_data  out  128  ciphertext.
- key_load  out  1  load/run request to the round-key expander.
- rk  in  128  round key from the expander.
- rk_idx  in  5  round number of rk; values >Nr mean no key available.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, key_load=0, state register=0, round counter r=0, FSM in IDLE.
- FSM states:
  - IDLE: in_ready=1, key_load=0. On in_valid&&in_ready, capture in_data into the state register, set r=0, go to KEYWAIT. The transfer takes one cycle.
  - KEYWAIT: key_load=1.
    - If rk_idx==0: state ^= rk, r=1, go to ROUND.
    - Otherwise stall.
  - ROUND: key_load=1. Apply the round to the state only in a cycle where rk_idx==r; otherwise stall with the state held.
    - For r<Nr: SubBytes, ShiftRows, MixColumns, AddRoundKey(rk); then r=r+1.
    - For r==Nr: same round without MixColumns; load the result into out_data and go to DONE.
  - DONE: out_valid=1, out_data stable, key_load=0.
    - On out_ready: out_valid=0, go to IDLE.
    - key_load is low in DONE, so the expander always sees at least one low cycle and restarts from key 0 for the next block.
- in_ready=0 in every state except IDLE. No new block is accepted while a result is pending (no overlap).
- Latency: in_valid handshake to out_valid is Nr+2 cycles plus any expander start-up and stall cycles. With an expander that delivers one key per cycle starting the cycle after load, Nk=4 gives 13 cycles minimum.
- rk_idx lower than r (repeated key): ignored, stall.
- rk_idx higher than r (skipped key): without the optional feature, stall forever until reset. This is a documented integration error.
- out_ready held high in DONE: one-cycle pulse of out_valid.
- in_valid asserted while busy: ignored, and the data is not captured.
- rst_n low mid-block: immediate return to the reset values; the partial state is discarded; key_load drops asynchronously.
- Arithmetic:
  - GF(2^8) with polynomial 0x11B. xtime(b) = (b<<1) ^ (b[7] ? 8'h1B : 0).
  - MixColumns uses the standard {02,03,01,01} circulant.
  - ShiftRows: row i rotates left by i columns. Column c consists of bytes 4c..4c+3.

Optional Feature:
- Macro: AES_RK_ORDER_CHECK_EN.
- Defined:
  - Adds output port rk_err (1 bit, reset 0).
  - In KEYWAIT/ROUND, if rk_idx<=Nr and rk_idx>r, rk_err is set sticky and the FSM aborts to IDLE with out_valid never asserted.
  - rk_err clears only on rst_n.
- Undefined: no port and no check; the stall behaviour above applies.

Decomposition:
- Package aes_pkg holds:
  - SBOX[256] and RCON constants, shared with the expander.
  - xtime function.
  - aes_state_t typedef (logic [15:0][7:0]).
  - FSM enum cipher_st_e {IDLE, KEYWAIT, ROUND, DONE}.
- One sub-module, aes_round: purely combinational.
  - Inputs: state, rk, final_rnd. Output: next state.
  - Performs SubBytes, ShiftRows, MixColumns (skipped when final_rnd), AddRoundKey.
  - The top level keeps the FSM, counter and handshakes.

Test Plan:
- Nk=4 vector:
  - Stimulus: in_data=128'hffeeddccbbaa99887766554433221100 with round keys from key 128'h0f0e0d0c0b0a09080706050403020100, one per cycle.
  - Response: out_data=128'h5ac5b47080b7cdd830047b6ad8e0c469, out_valid 13 cycles after the accept handshake.
- Nk=8 vector:
  - Stimulus: same plaintext, key bytes 00..1f.
  - Response: out_data=128'h8960494b9049fceabf456751cab7a28e (FIPS 8ea2b7ca516745bfeafc49904b496089).
- Backpressure: out_ready held 0 for 5 cycles in DONE -> out_data stable, in_ready=0, key_load=0; ciphertext is released on the first out_ready=1.
- Stall: hold rk_idx at 3 for 4 extra cycles mid-block -> same ciphertext, latency +4.
- Reset mid-block: pull rst_n low at round 5 -> all outputs return to 0 at once. The next block then encrypts correctly.
- AES_RK_ORDER_CHECK_EN: jump rk_idx from 2 to 4 -> rk_err=1, FSM returns to IDLE, out_valid stays 0.
